conv_window_feeder: RTL and testbench



---
 rtl/conv_window_feeder_pkg.sv | 35 +++
 rtl/conv_window_feeder_ring.sv | 33 +++
 rtl/conv_window_feeder.sv | 190 +++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_feeder_pkg.sv
// Shared state encoding, default geometry and small helpers for the conv window feeder.
package conv_feed_pkg;

    localparam int DEF_IMG_W  = 9;
    localparam int DEF_IMG_H  = 9;
    localparam int DEF_STRIDE = 2;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;
    localparam int COL_W      = 4;
    localparam int ROW_W      = 4;

    // Q6.10 pixel as used across the fixed-point datapath
    typedef logic signed [DEF_DATA_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_INIT,
        LOAD_NEXT,
        WAIT,
        STREAM,
        DONE
    } feed_state_e;

    function automatic int n_out(input int img_h, input int stride);
        return (img_h - 3) / stride + 1;
    endfunction

    // (a + b) mod 3 for ring slot arithmetic; both operands are already in 0..2
    function automatic logic [1:0] slot_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/conv_window_feeder_ring.sv
// Three line buffers organised as a ring; one write port and one rotated column read.
module line_ring_buffer
    import conv_feed_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clock,
    input  logic                   wr_en,
    input  logic [1:0]             wr_slot,
    input  logic [COL_W-1:0]       wr_col,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [COL_W-1:0]       rd_col,
    input  logic [1:0]             rd_top,
    output logic [2:0][DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [3][IMG_W];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_slot][wr_col] <= wr_data;
        end
    end

    // Element [2] is the window top row, which lives in slot rd_top
    for (genvar i = 0; i < 3; i++) begin : g_row
        logic [1:0] slot;
        assign slot       = slot_add(rd_top, 2'(2 - i));
        assign rd_data[i] = mem[slot][rd_col];
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Loads image rows from a synchronous RAM into a 3-line ring and streams
// 3-element columns for each vertically strided window row.
module conv_window_feeder
    import conv_feed_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int STRIDE = DEF_STRIDE,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_rd_data,
    output logic [2:0][DATA_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COL_W-1:0]       out_col,
    output logic [ROW_W-1:0]       out_row,
    output logic                   out_first,
    output logic                   out_last
);

    localparam int               N_OUT    = n_out(IMG_H, STRIDE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_OUT - 1);
    localparam logic [1:0]       STEP     = 2'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    feed_state_e          state;
    logic [1:0]           top;
    logic [1:0]           ld_k;
    logic [1:0]           ld_rows;
    logic [COL_W-1:0]     ld_col;
    logic [ADDR_W-1:0]    row_base;
    logic [1:0]           iss_slot;
    logic [COL_W-1:0]     iss_col;
    logic                 wb_vld;
    logic [1:0]           wb_slot;
    logic [COL_W-1:0]     wb_col;
    logic [COL_W-1:0]     ring_rd_col;
    logic [2:0][DATA_W-1:0] ring_col;

    assign ld_rows = (state == LOAD_INIT) ? 2'd3 : STEP;

    // Column presented at the next register update: col 0 on entry, col+1 while streaming
    assign ring_rd_col = (state == STREAM && out_col != COL_LAST) ? out_col + 4'd1 : '0;

    line_ring_buffer #(
        .IMG_W  (IMG_W),
        .DATA_W (DATA_W)
    ) u_ring (
        .clock   (clock),
        .wr_en   (wb_vld),
        .wr_slot (wb_slot),
        .wr_col  (wb_col),
        .wr_data (mem_rd_data),
        .rd_col  (ring_rd_col),
        .rd_top  (top),
        .rd_data (ring_col)
    );

    // Read tags travel one stage behind mem_rd_en to meet the returning RAM data
    always_ff @(posedge clock) begin
        if (!reset) begin
            wb_vld  <= 1'b0;
            wb_slot <= '0;
            wb_col  <= '0;
        end else begin
            wb_vld  <= mem_rd_en;
            wb_slot <= iss_slot;
            wb_col  <= iss_col;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            iss_slot  <= '0;
            iss_col   <= '0;
            top       <= '0;
            ld_k      <= '0;
            ld_col    <= '0;
            row_base  <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_row   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD_INIT;
                        busy     <= 1'b1;
                        row_base <= '0;
                        ld_k     <= '0;
                        ld_col   <= '0;
                        out_row  <= '0;
                    end
                end

                LOAD_INIT, LOAD_NEXT: begin
                    if (ld_k == ld_rows) begin
                        mem_rd_en <= 1'b0;
                        state     <= WAIT;
                        // New rows replaced the oldest slots, so the window top moves down
                        if (state == LOAD_NEXT) begin
                            top <= slot_add(top, STEP);
                        end
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= row_base + ADDR_W'(ld_col);
                        iss_slot  <= slot_add(top, ld_k);
                        iss_col   <= ld_col;
                        if (ld_col == COL_LAST) begin
                            ld_col   <= '0;
                            ld_k     <= ld_k + 2'd1;
                            row_base <= row_base + ROW_STEP;
                        end else begin
                            ld_col <= ld_col + 4'd1;
                        end
                    end
                end

                WAIT: begin
                    state     <= STREAM;
                    out_valid <= 1'b1;
                    out_col   <= '0;
                    out_first <= 1'b1;
                    out_last  <= 1'b0;
                    out_data  <= ring_col;
                end

                STREAM: begin
                    if (out_ready) begin
                        if (out_col == COL_LAST) begin
                            out_valid <= 1'b0;
                            out_first <= 1'b0;
                            out_last  <= 1'b0;
                            out_col   <= '0;
                            if (out_row == ROW_LAST) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                out_row <= out_row + 4'd1;
                                state   <= LOAD_NEXT;
                                ld_k    <= '0;
                                ld_col  <= '0;
                            end
                        end else begin
                            out_col   <= out_col + 4'd1;
                            out_first <= 1'b0;
                            out_data  <= ring_col;
                            out_last  <= (out_row == ROW_LAST) && (out_col + 4'd1 == COL_LAST);
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            assert (IMG_W * IMG_H <= (1 << ADDR_W) && (STRIDE == 1 || STRIDE == 2)
                    && ((IMG_H - 3) % STRIDE) == 0 && IMG_W >= 3);
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed/randomised bench for conv_window_feeder against a window-level reference model.
module tb_conv_window_feeder;

    localparam int IMG_W  = 9;
    localparam int IMG_H  = 9;
    localparam int STRIDE = 2;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int N_OUT  = (IMG_H - 3) / STRIDE + 1;
    localparam int NBEATS = N_OUT * IMG_W;
    localparam int NPIX   = IMG_W * IMG_H;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic                   busy, done, mem_rd_en;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_rd_data = '0;
    logic [2:0][DATA_W-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [3:0]             out_col, out_row;
    logic                   out_first, out_last;

    conv_window_feeder #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .STRIDE(STRIDE), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_row(out_row), .out_first(out_first), .out_last(out_last)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] ram [128];
    always @(posedge clock) if (mem_rd_en) mem_rd_data <= ram[mem_addr[6:0]];

    int errors = 0, checks = 0, cyc = 0;
    int hs_cnt, first_vld, rd_cnt, dones, viol, n_stall;
    int rd_cyc [$];
    logic [3*DATA_W-1:0] obs_data [$];
    logic obs_last [$];
    logic stall_q = 1'b0;
    logic [58:0] stall_snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctrl"}, 64'({busy, done, mem_rd_en, out_valid, out_first, out_last,
                                 out_col, out_row, mem_addr}), 64'(0));
        chk({tag, "_data"}, 64'(out_data), 64'(0));
    endtask

    // Window row w, column c: top/middle/bottom pixels of image rows w*STRIDE .. w*STRIDE+2
    function automatic logic [58:0] exp_beat(input int idx);
        int w, c, r0;
        w  = idx / IMG_W;
        c  = idx % IMG_W;
        r0 = w * STRIDE;
        return {ram[7'(r0 * IMG_W + c)], ram[7'((r0 + 1) * IMG_W + c)], ram[7'((r0 + 2) * IMG_W + c)],
                4'(c), 4'(w), c == 0, (w == N_OUT - 1) && (c == IMG_W - 1), 1'b1};
    endfunction

    task automatic tick();
        logic [58:0] cur;
        logic hs;
        cur = {out_data, out_col, out_row, out_first, out_last, out_valid};
        hs  = out_valid && out_ready && reset;
        if (stall_q) begin
            n_stall++;
            chk("hold", 64'(cur), 64'(stall_snap));
        end
        stall_q    = out_valid && !out_ready && reset;
        stall_snap = cur;
        if (hs) begin
            if (hs_cnt < NBEATS) chk("beat", 64'(cur), 64'(exp_beat(hs_cnt)));
            else chk("extra_beat", 64'(hs_cnt), 64'(NBEATS - 1));
            obs_data.push_back(out_data);
            obs_last.push_back(out_last);
            hs_cnt++;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (mem_rd_en) begin
            // The loads sweep the whole image row-major exactly once
            chk("rd_addr", 64'(mem_addr), 64'(rd_cnt));
            rd_cyc.push_back(cyc);
            rd_cnt++;
            if (out_valid || !busy) viol++;
        end
        if (done) dones++;
        if (out_valid && first_vld < 0) first_vld = cyc;
    endtask

    // mode 0: always ready, 1: ready 1,0,0,1 during window row 0, 2: random ready
    task automatic run_image(input int mode, input bit do_abort, input bit poke);
        int pat, abort_cyc;
        bit fin, aborted;
        hs_cnt = 0; first_vld = -1; rd_cnt = 0; dones = 0; viol = 0; n_stall = 0;
        rd_cyc.delete(); obs_data.delete(); obs_last.delete();
        pat = 0; fin = 0; aborted = 0; abort_cyc = 0; stall_q = 0;
        out_ready = 1'b1;
        start = 1'b1; cyc = -1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: if (out_valid && out_row == 0) begin
                       out_ready = (pat % 4 == 0) || (pat % 4 == 3);
                       pat++;
                   end else out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = poke && (cyc == 5 || cyc == 40);
            if (do_abort && !aborted && out_valid && out_row == 1 && out_col == 4) begin
                reset = 1'b0; aborted = 1; abort_cyc = cyc;
            end
            tick();
            if (!reset) begin
                reset = 1'b1;
                chk_reset("abort");
            end
            if (done) fin = 1;
            if (aborted && cyc >= abort_cyc + 40) fin = 1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("finished", 64'(fin), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = (i < NPIX) ? 16'(16 * (i / IMG_W) + i % IMG_W) : '0;

        // Reset state
        repeat (2) tick();
        chk_reset("reset");
        reset = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'(0));

        // Basic stream, ring rotation and read-port sequence
        run_image(0, 0, 0);
        chk("s1_first_valid_cyc", 64'(first_vld), 64'(3 * IMG_W + 2));
        chk("s1_beats", 64'(hs_cnt), 64'(NBEATS));
        chk("s1_reads", 64'(rd_cnt), 64'(NPIX));
        chk("s1_first_beat", 64'(obs_data[0]), 64'({16'd0, 16'd16, 16'd32}));
        chk("s2_row1_first", 64'(obs_data[9]), 64'({16'd32, 16'd48, 16'd64}));
        chk("s2_last_beat", 64'(obs_data[35]), 64'({16'd104, 16'd120, 16'd136}));
        chk("s2_last_flag", 64'(obs_last[35]), 64'(1));
        chk("s4_rd_start", 64'(rd_cyc[0]), 64'(1));
        chk("s4_rd_init_end", 64'(rd_cyc[26]), 64'(27));
        chk("s4_next_after_stream", 64'(rd_cyc[27] > 3 * IMG_W + 2 + IMG_W - 1), 64'(1));
        chk("s4_next_contig", 64'(rd_cyc[44] - rd_cyc[27]), 64'(17));
        chk("s4_next_gap", 64'(rd_cyc[45] - rd_cyc[44] > 1), 64'(1));
        chk("s1_rd_outside_load", 64'(viol), 64'(0));
        tick();
        chk("s1_done_one_cycle", 64'({done, busy}), 64'(0));
        chk("s1_done_count", 64'(dones), 64'(1));

        // Backpressure in window row 0
        run_image(1, 0, 0);
        chk("s3_beats", 64'(hs_cnt), 64'(NBEATS));
        chk("s3_stalled", 64'(n_stall > 0), 64'(1));
        chk("s3_rd_in_stream", 64'(viol), 64'(0));
        tick();

        // Reset at window row 1, col 4, then a clean rerun
        run_image(0, 1, 0);
        chk("s5_no_done", 64'(dones), 64'(0));
        chk("s5_beats_before_abort", 64'(hs_cnt), 64'(IMG_W + 4));
        run_image(0, 0, 0);
        chk("s5_rerun_first_valid", 64'(first_vld), 64'(3 * IMG_W + 2));
        chk("s5_rerun_beats", 64'(hs_cnt), 64'(NBEATS));
        chk("s5_rerun_last", 64'(obs_data[35]), 64'({16'd104, 16'd120, 16'd136}));
        tick();

        // start while busy and in the done cycle, then one cycle after done
        run_image(0, 0, 1);
        chk("s6_beats", 64'(hs_cnt), 64'(NBEATS));
        chk("s6_first_valid", 64'(first_vld), 64'(3 * IMG_W + 2));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s6_done_cycle_start", 64'(busy), 64'(0));
        run_image(0, 0, 0);
        chk("s6_after_done_beats", 64'(hs_cnt), 64'(NBEATS));
        chk("s6_after_done_first", 64'(first_vld), 64'(3 * IMG_W + 2));
        tick();

        // Random pixels with random backpressure
        for (int i = 0; i < NPIX; i++) ram[i] = 16'($urandom);
        run_image(2, 0, 0);
        chk("rnd_beats", 64'(hs_cnt), 64'(NBEATS));
        chk("rnd_reads", 64'(rd_cnt), 64'(NPIX));
        chk("rnd_rd_in_stream", 64'(viol), 64'(0));
        chk("rnd_done_count", 64'(dones), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
